clk_gate_ctrl: RTL and testbench



---
 rtl/clk_gate_pkg.sv | 21 ++
 rtl/clk_gate_chan.sv | 94 +++++++++
 rtl/clk_gate_ctrl.sv | 36 +++
 tb/tb_clk_gate_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/clk_gate_pkg.sv
// Shared definitions for the clock-gating controller: channel state encoding
// and the width rule for the per-channel wake/idle counter.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_IDLE = 2'd3
    } state_t;

    // Wide enough for max(wake, idle) - 1, never narrower than one bit.
    function automatic int cnt_width(input int wake_cycles, input int idle_cycles);
        int m;
        int w;
        m = (wake_cycles > idle_cycles) ? wake_cycles : idle_cycles;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clk_gate_chan.sv
// One gated-domain channel: OFF/WAKE/ON/IDLE FSM with a shared wake/idle
// down-counter, driving a registered gate enable and acknowledge.
module clk_gate_chan
    import clk_gate_pkg::*;
#(
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic req,
    input  logic force_on,
    output logic clk_en,
    output logic ack
);

    localparam int CW = cnt_width(WAKE_CYCLES, IDLE_CYCLES);
    localparam logic [CW-1:0] WAKE_LD = CW'(WAKE_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_LD = CW'(IDLE_CYCLES - 1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            en_nxt, ack_nxt;
    logic            ereq;

    assign ereq = req | force_on;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_OFF;
            cnt    <= '0;
            clk_en <= 1'b0;
            ack    <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            clk_en <= en_nxt;
            ack    <= ack_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        en_nxt    = 1'b1;
        ack_nxt   = 1'b0;
        case (state)
            ST_OFF: begin
                en_nxt = 1'b0;
                if (ereq) begin
                    state_nxt = ST_WAKE;
                    cnt_nxt   = WAKE_LD;
                    en_nxt    = 1'b1;
                end
            end
            // Request drops are ignored until the settling period has elapsed.
            ST_WAKE: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (ereq) begin
                    state_nxt = ST_ON;
                    ack_nxt   = req;
                end else begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = IDLE_LD;
                end
            end
            ST_ON: begin
                if (ereq) begin
                    ack_nxt = req;
                end else begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = IDLE_LD;
                end
            end
            // Clock is still running here, so a re-request skips the wake period.
            ST_IDLE: begin
                if (ereq) begin
                    state_nxt = ST_ON;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    state_nxt = ST_OFF;
                    en_nxt    = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_OFF;
                en_nxt    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Per-domain clock-gating controller: independent channels in parallel plus a
// registered "any domain enabled" summary.
module clk_gate_ctrl #(
    parameter int N_CH        = 2,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_CH-1:0] REQ,
    input  logic [N_CH-1:0] FORCE_ON,
    output logic [N_CH-1:0] CLK_EN,
    output logic [N_CH-1:0] ACK,
    output logic            ANY_ON
);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        clk_gate_chan #(
            .WAKE_CYCLES (WAKE_CYCLES),
            .IDLE_CYCLES (IDLE_CYCLES)
        ) u_chan (
            .CLK      (CLK),
            .RST      (RST),
            .req      (REQ[i]),
            .force_on (FORCE_ON[i]),
            .clk_en   (CLK_EN[i]),
            .ack      (ACK[i])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) ANY_ON <= 1'b0;
        else     ANY_ON <= |CLK_EN;
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl: directed test-plan sequences followed by
// random request/force/reset traffic, checked against a timing-rule model.
module tb_clk_gate_ctrl;

    localparam int N = 2;
    localparam int W = 2;
    localparam int I = 4;

    typedef struct {
        logic [N-1:0] en;
        logic [N-1:0] ack;
        logic         any;
        int           cyc;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [N-1:0] REQ = '0;
    logic [N-1:0] FORCE_ON = '0;
    logic [N-1:0] CLK_EN, ACK;
    logic         ANY_ON;

    clk_gate_ctrl #(.N_CH(N), .WAKE_CYCLES(W), .IDLE_CYCLES(I)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ      (REQ),
        .FORCE_ON (FORCE_ON),
        .CLK_EN   (CLK_EN),
        .ACK      (ACK),
        .ANY_ON   (ANY_ON)
    );

    always #5 CLK = ~CLK;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Model: the gate opens on the first effective request, ACK is allowed
    // from open+W onward, and it closes once ereq has been low on I+1
    // consecutive edges counted from the end of the wake window.
    bit   m_en  [N];
    bit   m_ack [N];
    bit   m_prev[N];
    int   m_rdy [N];
    int   m_low [N];

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] f, input logic rs);
        exp_t e;
        bit   ereq;
        @(negedge CLK);
        REQ = r; FORCE_ON = f; RST = rs;
        cyc++;
        e.any = 1'b0;
        for (int c = 0; c < N; c++) if (!rs && m_en[c]) e.any = 1'b1;
        for (int c = 0; c < N; c++) begin
            ereq = r[c] | f[c];
            if (rs) begin
                m_en[c] = 0; m_ack[c] = 0; m_low[c] = 0;
            end else if (!m_en[c]) begin
                if (ereq) begin m_en[c] = 1; m_rdy[c] = cyc + W; end
                m_ack[c] = 0; m_low[c] = 0;
            end else if (cyc < m_rdy[c]) begin
                m_ack[c] = 0;
            end else begin
                m_low[c] = ereq ? 0 : m_low[c] + 1;
                m_ack[c] = r[c] && (cyc == m_rdy[c] || m_prev[c]);
                if (m_low[c] == I + 1) begin m_en[c] = 0; m_ack[c] = 0; m_low[c] = 0; end
            end
            m_prev[c] = rs ? 1'b0 : ereq;
            e.en[c]  = m_en[c];
            e.ack[c] = m_ack[c];
        end
        e.cyc = cyc;
        q.push_back(e);
    endtask

    task automatic drive_n(input logic [N-1:0] r, input logic [N-1:0] f, input logic rs, input int n);
        for (int k = 0; k < n; k++) drive(r, f, rs);
    endtask

    // Monitor: every edge presents a new output vector; compare against the
    // oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                n_checks++;
                if (CLK_EN !== e.en) begin
                    n_fail++;
                    $display("FAIL clk_en cyc=%0d got=%b exp=%b", e.cyc, CLK_EN, e.en);
                end
                n_checks++;
                if (ACK !== e.ack) begin
                    n_fail++;
                    $display("FAIL ack cyc=%0d got=%b exp=%b", e.cyc, ACK, e.ack);
                end
                n_checks++;
                if (ANY_ON !== e.any) begin
                    n_fail++;
                    $display("FAIL any_on cyc=%0d got=%b exp=%b", e.cyc, ANY_ON, e.any);
                end
            end
        end
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] r, f;
        int           hold[N];
        for (int c = 0; c < N; c++) begin
            m_en[c] = 0; m_ack[c] = 0; m_prev[c] = 0; m_rdy[c] = 0; m_low[c] = 0; hold[c] = 0;
        end
        // reset, then short pulse on channel 1
        drive_n(2'b00, 2'b00, 1'b1, 3);
        drive_n(2'b00, 2'b00, 1'b0, 4);
        drive_n(2'b10, 2'b00, 1'b0, 1);
        drive_n(2'b00, 2'b00, 1'b0, 9);
        // basic wake/release on channel 0, with a re-request during idle
        drive_n(2'b01, 2'b00, 1'b0, 10);
        drive_n(2'b00, 2'b00, 1'b0, 2);
        drive_n(2'b01, 2'b00, 1'b0, 5);
        drive_n(2'b00, 2'b00, 1'b0, 8);
        // force-on with REQ toggling
        drive_n(2'b00, 2'b10, 1'b0, 8);
        drive_n(2'b10, 2'b10, 1'b0, 1);
        drive_n(2'b00, 2'b10, 1'b0, 1);
        drive_n(2'b10, 2'b10, 1'b0, 2);
        drive_n(2'b00, 2'b10, 1'b0, 3);
        drive_n(2'b00, 2'b00, 1'b0, 8);
        // parallel requests, then reset mid-operation with REQ held
        drive_n(2'b11, 2'b00, 1'b0, 6);
        drive_n(2'b11, 2'b00, 1'b1, 1);
        drive_n(2'b11, 2'b00, 1'b0, 6);
        drive_n(2'b00, 2'b00, 1'b0, 8);
        // random traffic
        r = '0; f = '0;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    r[c] = 1'($urandom_range(0, 1));
                    hold[c] = $urandom_range(0, 8);
                end else begin
                    hold[c]--;
                end
                if ($urandom_range(0, 63) == 0) f[c] = ~f[c];
            end
            drive(r, f, ($urandom_range(0, 149) == 0));
        end
        drive_n(2'b00, 2'b00, 1'b0, 10);
        @(negedge CLK);
        @(negedge CLK);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
